hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core, placed beside the ID stage. Detects load-use hazards and holds the front end for a configurable number of bubble cycles. Flushes IF/ID and ID/EX on taken branches/jumps resolved in EX. Freezes the whole pipeline while the data memory reports busy.

---
 rtl/hazard_ctrl_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch / dmem-busy hazard controller sitting beside the ID stage.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no load-use stall in progress; hazard detection is live
// LSTALL | extra bubble cycles after the first; cnt counts the rest down to 0
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  mem_read_id_ex,
    input  logic [REG_ADDR_W-1:0] rd_id_ex,
    input  logic [REG_ADDR_W-1:0] rs1_if_id,
    input  logic [REG_ADDR_W-1:0] rs2_if_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  branch_taken_ex,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } state_t;

    // The first bubble is issued from IDLE, so LSTALL covers the remaining N-1.
    localparam bit         MULTI_CYCLE = (LOAD_STALL_CYCLES > 1);
    localparam logic [3:0] CNT_RELOAD  = MULTI_CYCLE ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       hz;
    logic       stall;

    assign hz = mem_read_id_ex && (rd_id_ex != '0) &&
                ((rs1_used && (rd_id_ex == rs1_if_id)) ||
                 (rs2_used && (rd_id_ex == rs2_if_id)));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: reset > dmem freeze > taken branch > load-use stall.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;

        if (!arst_n) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (dmem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = IDLE;
            cnt_d       = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hz) begin
                        stall = 1'b1;
                        if (MULTI_CYCLE) begin
                            state_d = LSTALL;
                            cnt_d   = CNT_RELOAD;
                        end
                    end
                end
                LSTALL: begin
                    stall = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_taken_ex && !dmem_busy) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: three controllers (1/2/3 bubble cycles) on shared stimulus,
// each checked every cycle against a remaining-bubbles model, plus literal pins.
module tb_hazard_ctrl_unit;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       mem_read_id_ex = 1'b0;
    logic [4:0] rd_id_ex = '0;
    logic [4:0] rs1_if_id = '0;
    logic [4:0] rs2_if_id = '0;
    logic       rs1_used = 1'b0;
    logic       rs2_used = 1'b0;
    logic       branch_taken_ex = 1'b0;
    logic       dmem_busy = 1'b0;

    logic        o_pc   [NI];
    logic        o_ifid [NI];
    logic        o_bub  [NI];
    logic        o_iff  [NI];
    logic        o_idf  [NI];
    logic        o_frz  [NI];
    logic [31:0] o_sc   [NI];
    logic [31:0] o_fe   [NI];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        hazard_ctrl_unit #(
            .REG_ADDR_W       (5),
            .LOAD_STALL_CYCLES(g + 1),
            .CNT_W            (32)
        ) u_dut (
            .clk            (clk),
            .arst_n         (arst_n),
            .mem_read_id_ex (mem_read_id_ex),
            .rd_id_ex       (rd_id_ex),
            .rs1_if_id      (rs1_if_id),
            .rs2_if_id      (rs2_if_id),
            .rs1_used       (rs1_used),
            .rs2_used       (rs2_used),
            .branch_taken_ex(branch_taken_ex),
            .dmem_busy      (dmem_busy),
            .pc_write       (o_pc[g]),
            .if_id_write    (o_ifid[g]),
            .id_ex_bubble   (o_bub[g]),
            .if_id_flush    (o_iff[g]),
            .id_ex_flush    (o_idf[g]),
            .pipe_freeze    (o_frz[g]),
            .stall_cycles   (o_sc[g]),
            .flush_events   (o_fe[g])
        );
    end

    task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lsc=%0d: got %0d expected %0d at %0t", nm, k + 1, act, exp, $time);
        end
    endtask

    // Reference: each controller owes some number of further bubbles (rem).
    int          m_rem [NI] = '{0, 0, 0};
    logic [31:0] m_sc  [NI] = '{0, 0, 0};
    logic [31:0] m_fe  [NI] = '{0, 0, 0};

    function automatic bit model_hz();
        if (!mem_read_id_ex || rd_id_ex == 0) return 1'b0;
        return (rs1_used && rd_id_ex == rs1_if_id) || (rs2_used && rd_id_ex == rs2_if_id);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit          e_pc, e_ifid, e_bub, e_iff, e_idf, e_frz, e_stall;
            logic [31:0] e_sc, e_fe;
            if (!arst_n) begin
                m_rem[k] = 0;
                m_sc[k]  = 0;
                m_fe[k]  = 0;
            end
`ifdef HAZARD_PERF_CNT_EN
            e_sc = m_sc[k];
            e_fe = m_fe[k];
`else
            e_sc = 0;
            e_fe = 0;
`endif
            e_pc = 1; e_ifid = 1; e_bub = 0; e_iff = 0; e_idf = 0; e_frz = 0; e_stall = 0;
            if (!arst_n) begin
                e_stall = 0;
            end else if (dmem_busy) begin
                e_frz = 1; e_pc = 0; e_ifid = 0;
            end else if (branch_taken_ex) begin
                e_iff = 1; e_idf = 1;
                m_rem[k] = 0;
                m_fe[k]++;
            end else if (m_rem[k] > 0) begin
                e_stall = 1;
                m_rem[k]--;
            end else if (model_hz()) begin
                e_stall = 1;
                m_rem[k] = k;
            end
            if (e_stall) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
                m_sc[k]++;
            end
            cmp("pc_write",     k, 32'(o_pc[k]),   32'(e_pc));
            cmp("if_id_write",  k, 32'(o_ifid[k]), 32'(e_ifid));
            cmp("id_ex_bubble", k, 32'(o_bub[k]),  32'(e_bub));
            cmp("if_id_flush",  k, 32'(o_iff[k]),  32'(e_iff));
            cmp("id_ex_flush",  k, 32'(o_idf[k]),  32'(e_idf));
            cmp("pipe_freeze",  k, 32'(o_frz[k]),  32'(e_frz));
            cmp("stall_cycles", k, o_sc[k], e_sc);
            cmp("flush_events", k, o_fe[k], e_fe);
        end
    end

    task automatic clr();
        mem_read_id_ex = 0; rd_id_ex = 0; rs1_if_id = 0; rs2_if_id = 0;
        rs1_used = 0; rs2_used = 0; branch_taken_ex = 0; dmem_busy = 0;
    endtask

    task automatic load_use(input logic [4:0] r);
        clr();
        mem_read_id_ex = 1; rd_id_ex = r; rs1_if_id = r; rs1_used = 1;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    int st [NI];
    int frz;

    initial begin
        #1;
        arst_n = 0;
        load_use(5);
        at_sample();
        cmp("reset_pc_write", 2, 32'(o_pc[2]), 1);
        cmp("reset_bubble",   2, 32'(o_bub[2]), 0);
        to_next();
        to_next();
        arst_n = 1;

        // Load rd=5 followed by a reader of x5: 1/2/3 consecutive bubbles.
        st = '{0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            if (i == 0) load_use(5); else clr();
            at_sample();
            if (i == 0) begin
                cmp("first_stall_pc", 0, 32'(o_pc[0]), 0);
                cmp("first_stall_bub", 0, 32'(o_bub[0]), 1);
            end
            for (int k = 0; k < NI; k++) if (!o_pc[k]) st[k]++;
            to_next();
        end
        for (int k = 0; k < NI; k++) cmp("stall_length", k, 32'(st[k]), 32'(k + 1));

        // x0 and unused-source matches never stall.
        clr(); mem_read_id_ex = 1; rd_id_ex = 0; rs1_if_id = 0; rs1_used = 1;
        at_sample();
        cmp("x0_no_stall", 2, 32'(o_pc[2]), 1);
        to_next();
        clr(); mem_read_id_ex = 1; rd_id_ex = 7; rs2_if_id = 7; rs2_used = 0; rs1_if_id = 3; rs1_used = 1;
        at_sample();
        cmp("rs2_unused_no_stall", 2, 32'(o_pc[2]), 1);
        to_next();
        rs2_used = 1;
        at_sample();
        cmp("rs2_used_stall", 2, 32'(o_bub[2]), 1);
        to_next();
        clr();
        for (int i = 0; i < 3; i++) to_next();

        // Hazard and taken branch together: branch wins.
        load_use(9); branch_taken_ex = 1;
        at_sample();
        cmp("br_hz_if_id_flush", 2, 32'(o_iff[2]), 1);
        cmp("br_hz_id_ex_flush", 2, 32'(o_idf[2]), 1);
        cmp("br_hz_pc_write",    2, 32'(o_pc[2]), 1);
        to_next();
        clr();
        at_sample();
        cmp("br_hz_no_residual", 2, 32'(o_pc[2]), 1);
        to_next();

        // Branch while LSTALL has one count left ends the stall.
        load_use(9);
        to_next();
        clr(); branch_taken_ex = 1;
        at_sample();
        cmp("br_in_lstall_pc", 2, 32'(o_pc[2]), 1);
        cmp("br_in_lstall_flush", 2, 32'(o_iff[2]), 1);
        to_next();
        clr();
        at_sample();
        cmp("br_in_lstall_after", 2, 32'(o_pc[2]), 1);
        to_next();

        // Four busy cycles mid-stall: freeze for 4, still 3 stall cycles.
        st = '{0, 0, 0};
        frz = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) load_use(4);
            else begin clr(); dmem_busy = (i >= 2 && i <= 5); end
            at_sample();
            if (o_frz[2]) frz++;
            else if (!o_pc[2]) st[2]++;
            to_next();
        end
        cmp("freeze_cycles", 2, 32'(frz), 4);
        cmp("stall_around_freeze", 2, 32'(st[2]), 3);

        // Reset mid-LSTALL, then a fresh hazard stalls full length.
        load_use(6);
        to_next();
        clr(); arst_n = 0;
        at_sample();
        cmp("reset_mid_stall_pc", 2, 32'(o_pc[2]), 1);
        to_next();
        arst_n = 1;
        st = '{0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) load_use(6); else clr();
            at_sample();
            if (!o_pc[2]) st[2]++;
            to_next();
        end
        cmp("stall_after_reset", 2, 32'(st[2]), 3);

        // Two hazards and one branch on the 2-cycle controller.
        arst_n = 0;
        to_next();
        arst_n = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 3) load_use(2);
            else begin clr(); branch_taken_ex = (i == 6); end
            to_next();
        end
        clr();
        at_sample();
`ifdef HAZARD_PERF_CNT_EN
        cmp("perf_stall_cycles", 1, o_sc[1], 4);
        cmp("perf_flush_events", 1, o_fe[1], 1);
`else
        cmp("perf_stall_cycles", 1, o_sc[1], 0);
        cmp("perf_flush_events", 1, o_fe[1], 0);
`endif
        to_next();

        // Random traffic biased toward register-index collisions.
        for (int i = 0; i < 3000; i++) begin
            mem_read_id_ex  = 1'($urandom_range(0, 1));
            rd_id_ex        = 5'($urandom_range(0, 3));
            rs1_if_id       = 5'($urandom_range(0, 3));
            rs2_if_id       = 5'($urandom_range(0, 3));
            rs1_used        = 1'($urandom_range(0, 1));
            rs2_used        = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 9) == 0);
            dmem_busy       = ($urandom_range(0, 6) == 0);
            arst_n          = ($urandom_range(0, 199) != 0);
            to_next();
        end
        arst_n = 1;
        clr();
        to_next();
        to_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
